// File: rtl/button_event_debouncer.sv
// Per-channel 2-FF sync, debounce and press/release/long-press/repeat event generation.
// Latency: input -> o_Debounced after DEBOUNCE_LIMIT+2 edges; no backpressure, all outputs registered.
module button_event_debouncer #(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_PERIOD  = 2500000,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [NUM_BUTTONS-1:0] i_Buttons,
  output logic [NUM_BUTTONS-1:0] o_Debounced,
  output logic [NUM_BUTTONS-1:0] o_Press_Pulse,
  output logic [NUM_BUTTONS-1:0] o_Release_Pulse,
  output logic [NUM_BUTTONS-1:0] o_Long_Press,
  output logic [NUM_BUTTONS-1:0] o_Repeat_Pulse
);

  localparam int DW = $clog2(DEBOUNCE_LIMIT);
  localparam int HW = $clog2(HOLD_LIMIT);
  localparam int RW = $clog2(REPEAT_PERIOD);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} evt_state_t;

  logic [NUM_BUTTONS-1:0] sync_s1;
  logic [NUM_BUTTONS-1:0] sync_s2;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= i_Buttons;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar n = 0; n < NUM_BUTTONS; n++) begin : g_chan
    logic [DW-1:0] deb_cnt;
    logic          deb_q, press_q, rel_q, long_q, rpt_q;
    logic          deb_hit, press_acc, rel_acc;
    evt_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          long_d, rpt_d;

    // A new level is accepted only after DEBOUNCE_LIMIT consecutive differing samples.
    assign deb_hit   = (sync_s2[n] != deb_q) && (deb_cnt == DEB_MAX);
    assign press_acc = deb_hit &  sync_s2[n];
    assign rel_acc   = deb_hit & ~sync_s2[n];

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        deb_cnt <= '0;
        deb_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= press_acc;
        rel_q   <= rel_acc;
        if (sync_s2[n] == deb_q) begin
          deb_cnt <= '0;
        end else if (deb_hit) begin
          deb_q   <= sync_s2[n];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      long_d  = long_q;
      rpt_d   = 1'b0;
      case (state_q)
        IDLE: begin
          long_d = 1'b0;
          if (press_acc) begin
            state_d = PRESSED;
            hold_d  = '0;
          end
        end
        PRESSED: begin
          if (rel_acc) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == HOLD_MAX) begin
            state_d = HELD;
            hold_d  = '0;
            rep_d   = '0;
            long_d  = 1'b1;
            rpt_d   = REPEAT_EN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        HELD: begin
          // Release wins over a repeat hit landing in the same cycle.
          if (rel_acc) begin
            state_d = IDLE;
            rep_d   = '0;
            long_d  = 1'b0;
          end else if (rep_q == REP_MAX) begin
            rep_d = '0;
            rpt_d = REPEAT_EN;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
          rep_d   = '0;
          long_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        state_q <= IDLE;
        hold_q  <= '0;
        rep_q   <= '0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    assign o_Debounced[n]     = deb_q;
    assign o_Press_Pulse[n]   = press_q;
    assign o_Release_Pulse[n] = rel_q;
    assign o_Long_Press[n]    = long_q;
    assign o_Repeat_Pulse[n]  = rpt_q;
  end

endmodule

// File: tb/tb_button_event_debouncer.sv
// Directed bench: DEBOUNCE_LIMIT=4, HOLD_LIMIT=20, REPEAT_PERIOD=8; second instance has repeats disabled.
module tb_button_event_debouncer;
  logic       clk;
  logic       rst_l;
  logic [3:0] buttons;
  logic [3:0] deb, press, rel, lng, rpt;
  logic [3:0] nr_deb, nr_press, nr_rel, nr_lng, nr_rpt;
  int checks = 0;
  int errors = 0;

  button_event_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(20),
                           .REPEAT_PERIOD(8), .REPEAT_EN(1'b1)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Buttons(buttons),
    .o_Debounced(deb), .o_Press_Pulse(press), .o_Release_Pulse(rel),
    .o_Long_Press(lng), .o_Repeat_Pulse(rpt));

  button_event_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(20),
                           .REPEAT_PERIOD(8), .REPEAT_EN(1'b0)) dut_nr (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Buttons(buttons),
    .o_Debounced(nr_deb), .o_Press_Pulse(nr_press), .o_Release_Pulse(nr_rel),
    .o_Long_Press(nr_lng), .o_Repeat_Pulse(nr_rpt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sig(input int which);
    case (which)
      0:       return press;
      1:       return rel;
      default: return lng;
    endcase
  endfunction

  // Ticks until the selected output bit is high; n = edges taken, -1 on timeout.
  task automatic wait_bit(input int which, input int ch, input int limit, output int n);
    logic [3:0] v;
    bit hit;
    hit = 0;
    n = 0;
    while (!hit && n <= limit) begin
      tick();
      n++;
      v = sig(which);
      hit = v[ch];
    end
    if (!hit) n = -1;
  endtask

  initial begin
    int n;
    int pcnt, rcnt, long_rise, nr_rise, nr_rep;
    logic [63:0] rep_mask;
    clk = 0;
    rst_l = 0;
    buttons = '0;
    repeat (3) tick();
    check("reset_outs", {deb, press, rel, lng, rpt}, 20'h0);
    rst_l = 1;

    // 1: single press latency
    buttons = 4'b0001;
    repeat (5) tick();
    check("t1_deb_early", deb, 4'b0000);
    tick();
    check("t1_deb", deb, 4'b0001);
    check("t1_press", press, 4'b0001);
    tick();
    check("t1_press_1cyc", press, 4'b0000);
    buttons = 4'b0000;
    wait_bit(1, 0, 20, n);
    check("t1_rel_lat", n, 6);
    check("t1_rel_deb", {deb, lng}, 8'h00);

    // 2: bounce on btn1, then steady
    pcnt = 0;
    for (int r = 0; r < 5; r++) begin
      buttons[1] = 1'b1;
      repeat (3) begin tick(); pcnt += int'(press[1]) + int'(deb[1]); end
      buttons[1] = 1'b0;
      repeat (2) begin tick(); pcnt += int'(press[1]) + int'(deb[1]); end
    end
    check("t2_bounce_quiet", pcnt, 0);
    buttons[1] = 1'b1;
    wait_bit(0, 1, 20, n);
    check("t2_press_lat", n, 6);
    repeat (2) tick();
    buttons[1] = 1'b0;
    wait_bit(1, 1, 20, n);
    check("t2_rel_lat", n, 6);

    // boundary: exactly DEBOUNCE_LIMIT-cycle pulse is accepted
    buttons[3] = 1'b1;
    repeat (4) tick();
    buttons[3] = 1'b0;
    pcnt = 0; rcnt = 0;
    repeat (12) begin tick(); pcnt += int'(press[3]); rcnt += int'(rel[3]); end
    check("bnd_press_cnt", pcnt, 1);
    check("bnd_rel_cnt", rcnt, 1);

    // 3 + 6: long press and repeat timing on btn2
    buttons[2] = 1'b1;
    wait_bit(0, 2, 20, n);
    check("t3_press_lat", n, 6);
    long_rise = -1; nr_rise = -1; nr_rep = 0; rep_mask = '0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (lng[2] && long_rise < 0) long_rise = j;
      if (nr_lng[2] && nr_rise < 0) nr_rise = j;
      if (rpt[2]) rep_mask[j] = 1'b1;
      nr_rep += int'(|nr_rpt);
    end
    check("t3_long_rise", long_rise, 20);
    check("t3_rep_offsets", rep_mask, (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 36));
    check("t3_deb_only2", deb, 4'b0100);
    check("t6_nr_long_rise", nr_rise, 20);
    check("t6_nr_no_repeat", nr_rep, 0);
    buttons[2] = 1'b0;
    wait_bit(1, 2, 20, n);
    check("t3_rel_lat", n, 6);
    check("t3_long_drop", {lng[2], deb[2]}, 2'b00);

    // 4: simultaneous press, independent release
    buttons = 4'b1001;
    wait_bit(0, 0, 20, n);
    check("t4_press_lat", n, 6);
    check("t4_press_both", press, 4'b1001);
    repeat (3) tick();
    buttons = 4'b0001;
    wait_bit(1, 3, 20, n);
    check("t4_rel3_lat", n, 6);
    check("t4_rel_only3", {rel, deb}, 8'h81);
    repeat (10) tick();
    check("t4_long0_early", lng, 4'b0000);
    tick();
    check("t4_long0", {lng, rpt, deb}, 12'h111);
    buttons = 4'b0000;
    wait_bit(1, 0, 20, n);
    check("t4_rel0_lat", n, 6);
    check("t4_long0_drop", lng, 4'b0000);

    // 5: reset while btn1 is HELD, button kept down
    buttons = 4'b0010;
    wait_bit(0, 1, 20, n);
    check("t5_press_lat", n, 6);
    repeat (20) tick();
    check("t5_held", lng, 4'b0010);
    rst_l = 0;
    tick();
    check("t5_reset_outs", {deb, press, rel, lng, rpt}, 20'h0);
    rst_l = 1;
    wait_bit(0, 1, 20, n);
    check("t5_repress_lat", n, 6);
    check("t5_repress_long", lng, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
